// File: rtl/noc_pkg.sv
// Shared definitions for the NoC router: output port indices, packet length,
// arbiter sentinel, input-unit FSM states and the XY route computation.
package noc_pkg;

  // Output port order as seen by the per-output arbiters.
  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  localparam int unsigned PKT_FLITS = 5;
  localparam logic [2:0]  NO_GRANT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  // Dimension-ordered route: resolve X first, then Y, else deliver locally.
  // Returns a one-hot request vector indexed by port_e.
  function automatic logic [4:0] xy_route(input int unsigned dst_x,
                                          input int unsigned dst_y,
                                          input int unsigned my_x,
                                          input int unsigned my_y);
    logic [4:0] r;
    if (dst_x > my_x) begin
      r = 5'b00001 << PORT_E;
    end else if (dst_x < my_x) begin
      r = 5'b00001 << PORT_W;
    end else if (dst_y > my_y) begin
      r = 5'b00001 << PORT_N;
    end else if (dst_y < my_y) begin
      r = 5'b00001 << PORT_S;
    end else begin
      r = 5'b00001 << PORT_L;
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with registered occupancy count. Writes at full and
// reads at empty are ignored; pointers wrap naturally since DEPTH is 2^n.
module noc_flit_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              wr_s;
  logic              rd_s;

  assign wr_s      = wr_en_i & ~full_o;
  assign rd_s      = rd_en_i & ~empty_o;
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(wr_s) - CW'(rd_s);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/noc_input_unit.sv
// Router input port: buffers flits, routes each head flit XY-first, requests
// the chosen output arbiter and streams one fixed-length packet per grant.
module noc_input_unit
  import noc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned X_W    = 2,
  parameter int unsigned Y_W    = 2,
  parameter int unsigned MY_X   = 0,
  parameter int unsigned MY_Y   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_flit_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [4:0]        req_o,
  input  logic              grant_i,
  output logic [DATA_W-1:0] flit_o,
  output logic              flit_valid_o,
  input  logic              out_ready_i,
  output logic              xfer_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              fifo_wr_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic [CW-1:0]     fifo_count_s;
  logic [4:0]        head_route_s;
  logic              last_s;

  state_e            state_q;
  logic [4:0]        route_q;
  logic [4:0]        req_q;
  logic [2:0]        cnt_q;

  // Ready depends only on the registered count, so a pop never frees a slot
  // for a write in the same cycle.
  assign in_ready_o   = (fifo_count_s < CW'(DEPTH));
  assign fifo_wr_s    = in_valid_i & in_ready_o & ~fifo_full_s;

  assign head_route_s = xy_route(32'(fifo_head_s[X_W+Y_W-1:Y_W]),
                                 32'(fifo_head_s[Y_W-1:0]), MY_X, MY_Y);

  // An underrun mid-packet simply deasserts valid; the packet keeps its grant.
  assign flit_valid_o = (state_q == ST_XFER) & ~fifo_empty_s;
  assign xfer_o       = flit_valid_o & out_ready_i;
  assign flit_o       = flit_valid_o ? fifo_head_s : '0;
  assign last_s       = (cnt_q == 3'(PKT_FLITS - 1));
  assign req_o        = req_q;

  noc_flit_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (fifo_wr_s),
    .wr_data_i (in_flit_i),
    .rd_en_i   (xfer_o),
    .rd_data_o (fifo_head_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_count_s)
  );

  // Packet FSM: route latch, request hold and flit counting; returning to IDLE
  // for one cycle after the last flit gives the arbiter its re-arbitration gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      route_q <= 5'b00000;
      req_q   <= 5'b00000;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            route_q <= head_route_s;
            req_q   <= head_route_s;
            cnt_q   <= 3'd0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          req_q <= route_q;
          if (grant_i) begin
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (xfer_o) begin
            if (last_s) begin
              state_q <= ST_IDLE;
              req_q   <= 5'b00000;
              cnt_q   <= 3'd0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 5'b00000;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_input_unit.sv
// Bench for noc_input_unit (MY=(1,1), DEPTH=8): a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_noc_input_unit;

  localparam int DEPTH = 8;
  localparam int MYX   = 1;
  localparam int MYY   = 1;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_flit_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  req_o;
  logic        grant_man;
  logic        auto_grant;
  logic        grant_s;
  logic [31:0] flit_o;
  logic        flit_valid_o;
  logic        out_ready_i;
  logic        xfer_o;

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;

  // reference model state
  logic [31:0] mq[$];
  logic [4:0]  m_req    = 5'b0;
  bit          m_stream = 1'b0;
  int          m_sent   = 0;

  assign grant_s = grant_man | (auto_grant & (req_o != 5'b0));

  noc_input_unit #(
    .DATA_W (32), .DEPTH (DEPTH), .X_W (2), .Y_W (2), .MY_X (MYX), .MY_Y (MYY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_flit_i    (in_flit_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .req_o        (req_o),
    .grant_i      (grant_s),
    .flit_o       (flit_o),
    .flit_valid_o (flit_valid_o),
    .out_ready_i  (out_ready_i),
    .xfer_o       (xfer_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_flit(input int id, input int idx, input int x, input int y);
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] xx;
    logic [1:0] yy;
    a = 8'(id); b = 8'(idx); xx = 2'(x); yy = 2'(y);
    return {a, b, 12'h000, xx, yy};
  endfunction

  // XY rule from the routing description: port index N0 S1 E2 W3 L4.
  function automatic logic [4:0] model_route(input logic [31:0] f);
    int dx;
    int dy;
    int idx;
    dx = int'(f[3:2]);
    dy = int'(f[1:0]);
    if (dx > MYX)      idx = 2;
    else if (dx < MYX) idx = 3;
    else if (dy > MYY) idx = 0;
    else if (dy < MYY) idx = 1;
    else               idx = 4;
    return 5'(1 << idx);
  endfunction

  // Model update on the clock edge, using pre-edge inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_req    = 5'b0;
      m_stream = 1'b0;
      m_sent   = 0;
    end else begin
      bit do_rd;
      bit do_wr;
      bit g;
      do_rd = m_stream && (mq.size() > 0) && out_ready_i;
      do_wr = in_valid_i && (mq.size() < DEPTH);
      g     = grant_man | (auto_grant & (m_req != 5'b0));
      if (!m_stream && m_req == 5'b0) begin
        if (mq.size() > 0) m_req = model_route(mq[0]);
      end else if (!m_stream) begin
        if (g) begin m_stream = 1'b1; m_sent = 0; end
      end else if (do_rd) begin
        m_sent++;
        if (m_sent == 5) begin m_stream = 1'b0; m_req = 5'b0; end
      end
      if (do_rd) void'(mq.pop_front());
      if (do_wr) mq.push_back(in_flit_i);
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    bit          exp_fv;
    logic [31:0] exp_flit;
    exp_fv   = m_stream && (mq.size() > 0);
    exp_flit = exp_fv ? mq[0] : 32'h0;
    check("model_in_ready", 32'(in_ready_o), 32'(mq.size() < DEPTH));
    check("model_req", 32'(req_o), 32'(m_req));
    check("model_flit_valid", 32'(flit_valid_o), 32'(exp_fv));
    check("model_flit", flit_o, exp_flit);
    check("model_xfer", 32'(xfer_o), 32'(exp_fv && out_ready_i));
    if (xfer_o) xfer_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic [31:0] f);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    in_flit_i  = f;
    while (!in_ready_o && n < 200) begin step(); n++; end
    if (n >= 200) check("send_timeout", 32'(in_ready_o), 32'd1);
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic send_packet(input int id, input int x, input int y);
    for (int i = 0; i < 5; i++) send_flit(mk_flit(id, i, x, y));
  endtask

  task automatic wait_req(input string name, input logic [4:0] lit);
    int n;
    n = 0;
    while (req_o == 5'b0 && n < 50) begin step(); n++; end
    check(name, 32'(req_o), 32'(lit));
  endtask

  task automatic pulse_grant();
    grant_man = 1'b1;
    step();
    grant_man = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (req_o != 5'b0 && n < 300) begin step(); n++; end
    check(name, 32'(req_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs[5];
    int ys[5];
    logic [4:0] rq[5];
    int base;

    rst_n = 1'b0; in_valid_i = 1'b0; in_flit_i = 32'h0;
    grant_man = 1'b0; auto_grant = 1'b0; out_ready_i = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      in_valid_i  = 1'($urandom_range(0, 1));
      in_flit_i   = $urandom;
      grant_man   = 1'($urandom_range(0, 1));
      out_ready_i = 1'($urandom_range(0, 1));
      step();
      check("rst_in_ready", 32'(in_ready_o), 32'd1);
      check("rst_req", 32'(req_o), 32'd0);
      check("rst_flit_valid", 32'(flit_valid_o), 32'd0);
      check("rst_flit", flit_o, 32'h0);
      check("rst_xfer", 32'(xfer_o), 32'd0);
    end
    in_valid_i = 1'b0; in_flit_i = 32'h0; grant_man = 1'b0; out_ready_i = 1'b1;
    rst_n = 1'b1;
    step();

    // route coverage
    xs = '{3, 0, 1, 1, 1};
    ys = '{1, 2, 2, 0, 1};
    rq = '{5'b00100, 5'b01000, 5'b00001, 5'b00010, 5'b10000};
    for (int p = 0; p < 5; p++) begin
      send_packet(16 + p, xs[p], ys[p]);
      wait_req($sformatf("route_%0d_%0d", xs[p], ys[p]), rq[p]);
      pulse_grant();
      wait_idle("route_drain");
    end

    // single packet to E with exact timing
    send_packet(8'h40, 2, 1);
    wait_req("e_req", 5'b00100);
    base = xfer_cnt;
    pulse_grant();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("e_xfer_%0d", i), 32'(xfer_o), 32'd1);
      check($sformatf("e_flit_%0d", i), flit_o, mk_flit(8'h40, i, 2, 1));
      step();
    end
    check("e_req_gone", 32'(req_o), 32'd0);
    step();
    check("e_xfer_count", 32'(xfer_cnt - base), 32'd5);

    // backpressure 1,0,1,0...
    send_packet(8'h50, 0, 0);
    wait_req("bp_req", 5'b01000);
    base = xfer_cnt;
    pulse_grant();
    for (int k = 0; k < 40 && req_o != 5'b0; k++) begin
      out_ready_i = (k % 2 == 0);
      step();
    end
    out_ready_i = 1'b1;
    step();
    check("bp_xfer_count", 32'(xfer_cnt - base), 32'd5);
    check("bp_req_idle", 32'(req_o), 32'd0);

    // full FIFO then drain three packets across the pointer wrap
    for (int i = 0; i < 5; i++) send_flit(mk_flit(8'h60, i, 3, 3));
    for (int i = 0; i < 3; i++) send_flit(mk_flit(8'h61, i, 1, 3));
    check("full_ready", 32'(in_ready_o), 32'd0);
    in_valid_i = 1'b1;
    in_flit_i  = mk_flit(8'h61, 3, 1, 3);
    step(); step(); step();
    check("full_hold", 32'(in_ready_o), 32'd0);
    check("full_req", 32'(req_o), 32'(5'b00100));
    base = xfer_cnt;
    auto_grant = 1'b1;
    for (int n = 0; n < 50 && !in_ready_o; n++) step();
    step();
    in_valid_i = 1'b0;
    send_flit(mk_flit(8'h61, 4, 1, 3));
    for (int i = 0; i < 5; i++) send_flit(mk_flit(8'h62, i, 1, 1));
    for (int n = 0; n < 300 && (xfer_cnt - base) < 15; n++) step();
    check("full_drain_xfers", 32'(xfer_cnt - base), 32'd15);
    wait_idle("full_idle");
    auto_grant = 1'b0;

    // asynchronous reset after the 2nd transfer
    send_packet(8'h70, 1, 0);
    wait_req("ar_req", 5'b00010);
    base = xfer_cnt;
    pulse_grant();
    step();
    step();
    out_ready_i = 1'b0;
    #3;
    check("ar_two_xfers", 32'(xfer_cnt - base), 32'd2);
    rst_n = 1'b0;
    #1;
    check("ar_req_low", 32'(req_o), 32'd0);
    check("ar_fv_low", 32'(flit_valid_o), 32'd0);
    check("ar_xfer_low", 32'(xfer_o), 32'd0);
    step(); step();
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    step(); step();
    check("ar_fifo_empty_req", 32'(req_o), 32'd0);
    check("ar_ready", 32'(in_ready_o), 32'd1);
    send_packet(8'h71, 3, 0);
    wait_req("ar_next_req", 5'b00100);
    base = xfer_cnt;
    pulse_grant();
    check("ar_next_flit0", flit_o, mk_flit(8'h71, 0, 3, 0));
    wait_idle("ar_next_idle");
    step();
    check("ar_next_xfers", 32'(xfer_cnt - base), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
